rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 one-bit multiplexer path between four requesters. It grants one requester at a time and drives the 2-bit mux select and a one-hot grant vector. It also registers the selected data bit. It bounds each tenure with a hold counter so no requester can starve the others. It sits between requester logic and the gate-level 4:1 mux datapath.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one grant may be held (legal 1..255)
CNT_W, 8, width of hold counter (must hold MAX_HOLD)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  4  request per requester; req[i] held high while requester i wants the path
din  input  4  data bit per requester (mux data inputs)
grant  output  4  one-hot grant, registered; all zero when idle
sel  output  2  mux select, registered; index of current/last owner
busy  output  1  high while any grant is active
dout  output  1  registered mux output: din[sel] sampled while busy, else 0

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0000, sel=00, busy=0, dout=0, cnt=0, last=3 (requester 0 has highest priority after reset). Outputs take these values immediately, including mid-grant.
- All outputs and state are registered; no combinational path from req to grant.
- Priority: rotating; search order last+1, last+2, last+3, last (mod 4). The previous owner is lowest priority.
- IDLE: if req!=0 at an edge, pick the winner w. Load grant=1<<w, sel=w, busy=1, cnt=1, state=GRANT. Request-to-grant latency is 1 cycle. If req=0, remain IDLE.
- GRANT, owner o, at each edge:
  - Release condition: req[o]==0 OR cnt==MAX_HOLD.
  - No release: cnt<=cnt+1, grant/sel unchanged.
  - Release: last<=o. Re-arbitrate in the same edge using the rotated order from o+1.
    - If any req is pending (o included, as lowest priority), grant the new winner with cnt=1. There is no idle gap.
    - If no req is pending: grant=0000, busy=0, state=IDLE. sel keeps o.
- A requester reasserting in the cycle it was released is treated as any other requester, at lowest priority.
- Multiple simultaneous requests in IDLE: the rotated order decides. Non-one-hot req is legal.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, giving strict per-cycle round robin.
- dout: at each edge, dout<=busy ? din[sel] : 0, using the pre-edge sel/busy. dout therefore lags grant by 1 cycle.
- cnt never exceeds MAX_HOLD. No wrap-around is possible within legal parameters.
- X/Z on req is not handled. Requesters must drive known values out of reset.

Decomposition:
- Shared package/header: state encodings IDLE=1'b0, GRANT=1'b1; NUM_REQ=4; SEL_W=2.
- One sub-module: rr_pick4. It is combinational, with inputs req[3:0] and last[1:0], and outputs any and win[1:0] from the rotating-priority search. It is reused for both the IDLE and release decisions.
- Top holds the FSM, hold counter, last register, grant/sel/busy/dout registers.

Test Plan:
- Reset priority: reset, then req=1111 held, MAX_HOLD=8. Grants must be 0001 for 8 cycles, then 0010, 0100, 1000, 0001, each for 8 cycles with no gaps. sel must follow 0,1,2,3,0.
- Voluntary release: req=0100 for 3 cycles, then 0000. Requirements:
  - grant=0100 and sel=2 one cycle after req rises.
  - grant=0000 and busy=0 one cycle after req drops.
  - sel stays 2.
- Back-to-back handoff: owner 1 active, req changes 0010→1001 at the same edge. Next grant is 1000 (order 2,3,0,1) with no idle cycle. Then, on release of 3, grant is 0001.
- Sole requester at hold limit: MAX_HOLD=4, req=0001 constant. grant=0001 stays continuous, cnt cycles 1..4 and re-grants to 0 each time, busy never drops.
- Data path: owner 2, din=0100 then 1011. dout must be 1 then 0, each one cycle after din is applied. dout=0 while idle regardless of din.
- Async reset mid-grant: assert rst between edges while grant=1000, cnt=5. Outputs go to 0000/00/0/0 without a clock edge. After release, req=1111 grants 0001 first.

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Holds the FSM state encoding and the grant-vector helper.
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = 4'b0001 << idx;
    return vec;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Request/data bus between the requesters and the arbiter.
// Requesters drive req/din; the arbiter returns grant/sel/busy/dout.
interface rr_mux4_arbiter_if;
  import rr_mux4_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               dout;

  modport master (
    output req,
    output din,
    input  grant,
    input  sel,
    input  busy,
    input  dout
  );

  modport slave (
    input  req,
    input  din,
    output grant,
    output sel,
    output busy,
    output dout
  );

endinterface

// File: rtl/rr_mux4_arbiter_pick4.sv
// Rotating-priority picker: search starts just after 'last', so 'last'
// itself is considered only when no other requester is asking.
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [NUM_REQ-1:0] rot_s;
  logic [SEL_W-1:0]   off_s;
  logic [SEL_W-1:0]   idx_s;

  // rotate so bit 0 is the highest-priority requester, then priority-encode
  always_comb begin
    rot_s = 4'b0000;
    idx_s = 2'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx_s    = last + SEL_W'(j) + 2'd1;
      rot_s[j] = req[idx_s];
    end
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    any = |req;
    win = last + off_s + 2'd1;
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner of a shared 4:1 one-bit mux path with a bounded tenure;
// all outputs registered, no combinational path from req to grant.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux4_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               dout_q, dout_d;

  logic               any_s;
  logic [SEL_W-1:0]   win_s;
  logic [SEL_W-1:0]   pick_last_s;
  logic               release_s;

  // While granted, the current owner is the rotation origin, so one picker
  // serves both the idle decision and the same-edge handoff.
  assign pick_last_s = (state_q == GRANT) ? sel_q : last_q;
  assign release_s   = (~bus.req[sel_q]) | (cnt_q == CNT_W'(MAX_HOLD));

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (pick_last_s),
    .any  (any_s),
    .win  (win_s)
  );

  // next-state, tenure counter and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    dout_d  = busy_q ? bus.din[sel_q] : 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d = GRANT;
          grant_d = onehot4(win_s);
          sel_d   = win_s;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      GRANT: begin
        if (release_s) begin
          last_d = sel_q;
          if (any_s) begin
            grant_d = onehot4(win_s);
            sel_d   = win_s;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // state and output registers; last resets to 3 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.dout  = dout_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: two instances (hold limits 8 and 4) share stimulus;
// an ownership-level model is compared every cycle, plus literal spot checks.
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;

  int vectors     = 0;
  int miscompares = 0;

  rr_mux4_arbiter_if bus8 ();
  rr_mux4_arbiter_if bus4 ();

  assign bus8.req = req;
  assign bus8.din = din;
  assign bus4.req = req;
  assign bus4.din = din;

  rr_mux4_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  rr_mux4_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;

  // model state per instance: owner (-1 = idle), tenure length, last owner
  int   m_owner [2];
  int   m_ten   [2];
  int   m_last  [2];
  int   m_sel   [2];
  logic m_dout  [2];
  int   max_hold [2] = '{8, 4};

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 1; k <= 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_owner[d] <= -1;
        m_ten[d]   <= 0;
        m_last[d]  <= 3;
        m_sel[d]   <= 0;
        m_dout[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int o, t, l, s, w;
        logic nd;
        o = m_owner[d]; t = m_ten[d]; l = m_last[d]; s = m_sel[d];
        nd = (o >= 0) ? din[s] : 1'b0;
        if (o < 0) begin
          w = pick(req, l);
          if (w >= 0) begin o = w; t = 1; s = w; end
        end else if (!req[o] || t == max_hold[d]) begin
          l = o;
          w = pick(req, o);
          if (w >= 0) begin o = w; t = 1; s = w; end
          else o = -1;
        end else begin
          t = t + 1;
        end
        m_owner[d] <= o;
        m_ten[d]   <= t;
        m_last[d]  <= l;
        m_sel[d]   <= s;
        m_dout[d]  <= nd;
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          logic [3:0] eg;
          eg = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
          if (d == 0) begin
            chk("model grant h8", bus8.grant, eg);
            chk("model sel h8", {2'b00, bus8.sel}, 4'(m_sel[d]));
            chk("model busy h8", {3'b000, bus8.busy}, {3'b000, m_owner[d] >= 0});
            chk("model dout h8", {3'b000, bus8.dout}, {3'b000, m_dout[d]});
          end else begin
            chk("model grant h4", bus4.grant, eg);
            chk("model sel h4", {2'b00, bus4.sel}, 4'(m_sel[d]));
            chk("model busy h4", {3'b000, bus4.busy}, {3'b000, m_owner[d] >= 0});
            chk("model dout h4", {3'b000, bus4.dout}, {3'b000, m_dout[d]});
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " grant h8"}, bus8.grant, 4'b0000);
    chk({nm, " sel h8"}, {2'b00, bus8.sel}, 4'b0000);
    chk({nm, " busy h8"}, {3'b000, bus8.busy}, 4'b0000);
    chk({nm, " dout h8"}, {3'b000, bus8.dout}, 4'b0000);
    chk({nm, " grant h4"}, bus4.grant, 4'b0000);
  endtask

  logic [3:0] tbl_req [8] = '{4'b1010, 4'b1010, 4'b0110, 4'b0000, 4'b1101, 4'b0011, 4'b0011, 4'b1000};
  logic [3:0] tbl_din [8] = '{4'b1111, 4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b0001, 4'b1110, 4'b0110};

  initial begin
    fork
      compare_loop();
    join_none

    // reset state
    cyc(1);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // all requesting: 0,1,2,3,0 for 8 cycles each, no gaps
    req = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      chk("rr grant", bus8.grant, 4'b0001 << ((i / 8) % 4));
      chk("rr sel", {2'b00, bus8.sel}, 4'((i / 8) % 4));
    end
    req = 4'b0000;
    cyc(1);
    chk("rr idle grant", bus8.grant, 4'b0000);

    // voluntary release with data path on owner 2
    req = 4'b0100;
    cyc(1);
    chk("vol grant", bus8.grant, 4'b0100);
    chk("vol sel", {2'b00, bus8.sel}, 4'b0010);
    din = 4'b0100;
    cyc(1);
    chk("data dout1", {3'b000, bus8.dout}, 4'b0001);
    din = 4'b1011;
    cyc(1);
    chk("data dout0", {3'b000, bus8.dout}, 4'b0000);
    req = 4'b0000;
    din = 4'b1111;
    cyc(1);
    chk("vol rel grant", bus8.grant, 4'b0000);
    chk("vol rel busy", {3'b000, bus8.busy}, 4'b0000);
    chk("vol rel sel", {2'b00, bus8.sel}, 4'b0010);
    cyc(1);
    chk("idle dout", {3'b000, bus8.dout}, 4'b0000);

    // back-to-back handoff 1 -> 3 -> 0
    req = 4'b0010;
    cyc(1);
    chk("b2b own1", bus8.grant, 4'b0010);
    req = 4'b1001;
    cyc(1);
    chk("b2b own3", bus8.grant, 4'b1000);
    chk("b2b busy", {3'b000, bus8.busy}, 4'b0001);
    cyc(2);
    req = 4'b0001;
    cyc(1);
    chk("b2b own0", bus8.grant, 4'b0001);

    // sole requester at hold limit 4: continuous grant
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("sole grant h4", bus4.grant, 4'b0001);
      chk("sole busy h4", {3'b000, bus4.busy}, 4'b0001);
    end

    // async reset mid-grant (owner 3, tenure 5 on the hold-8 instance)
    req = 4'b0000;
    cyc(1);
    req = 4'b1000;
    cyc(1);
    chk("pre-rst grant", bus8.grant, 4'b1000);
    cyc(4);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("async rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 4'b1111;
    cyc(1);
    chk("post-rst grant h8", bus8.grant, 4'b0001);
    chk("post-rst grant h4", bus4.grant, 4'b0001);

    // mixed patterns checked by the model alone
    for (int i = 0; i < 8; i++) begin
      req = tbl_req[i];
      din = tbl_din[i];
      cyc(1);
    end
    req = 4'b0000;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
